// File: rtl/dprob_topk_select.sv
// Ranks boxes by prob_sel*scale/sum using exact cross-multiplied compares, keeps a sorted top-K list per frame,
// then drains K beats over valid/ready. Output appears 2 cycles after the frame-last sample; in_ready drops for flush+drain.
module dprob_topk_select #(
  parameter int DW = 16,
  parameter int AW = 8,
  parameter int SW = 3,
  parameter int K  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 valid_in,
  output logic                 in_ready,
  input  logic                 last_in,
  input  logic signed [DW-1:0] prob_max_in,
  input  logic signed [DW-1:0] prob_min_in,
  input  logic signed [DW-1:0] prob_sum_in,
  input  logic [DW-1:0]        scale_in,
  input  logic [AW-1:0]        addr_in,
  input  logic [SW-1:0]        set_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_hit,
  output logic [$clog2(K):0]   out_rank,
  output logic [AW-1:0]        out_addr,
  output logic [SW-1:0]        out_set,
  output logic signed [2*DW:0] out_num,
  output logic [DW:0]          out_den,
  output logic                 out_last,
  output logic [15:0]          drop_cnt
);

  localparam int RW = $clog2(K) + 1;
  localparam int IW = (K > 1) ? $clog2(K) : 1;
  localparam int NW = 2 * DW + 1;
  localparam int XW = 3 * DW + 2;

  localparam logic [1:0] ACCUM = 2'd0;
  localparam logic [1:0] FLUSH = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  typedef struct packed {
    logic                 vld;
    logic [AW-1:0]        addr;
    logic [SW-1:0]        set;
    logic signed [NW-1:0] num;
    logic [DW:0]          den;
  } slot_t;

  logic [1:0]    state;
  logic [RW-1:0] rank;
  slot_t         slot_q [K];

  logic                 s1_vld;
  logic                 s1_drop;
  logic [AW-1:0]        s1_addr;
  logic [SW-1:0]        s1_set;
  logic signed [NW-1:0] s1_num;
  logic [DW:0]          s1_den;

  logic                 accept;
  logic signed [DW-1:0] sel;
  logic signed [NW-1:0] prod;
  logic signed [NW-1:0] n_in;
  logic signed [DW:0]   d_raw;
  logic signed [DW:0]   d_in;

  logic [K-1:0]  gt;
  logic [RW-1:0] pos;
  logic          ins;
  slot_t         cur;
  logic          draining;

  assign in_ready = (state == ACCUM);
  assign accept   = valid_in & in_ready;

  // Sign of the sum picks the class prob; a negative denominator is folded into the numerator.
  always_comb begin
    sel   = prob_sum_in[DW-1] ? prob_min_in : prob_max_in;
    prod  = {{(DW+1){sel[DW-1]}}, sel} * {{(DW+1){1'b0}}, scale_in};
    d_raw = {prob_sum_in[DW-1], prob_sum_in};
    n_in  = prod;
    d_in  = d_raw;
    if (d_raw[DW]) begin
      n_in = -prod;
      d_in = -d_raw;
    end
  end

  // New sample beats a slot when N*D_i > N_i*D; equal scores keep the older entry ahead.
  always_comb begin
    gt  = '0;
    pos = '0;
    for (int i = 0; i < K; i++) begin
      gt[i] = slot_q[i].vld &&
              ($signed({{(XW-NW){s1_num[NW-1]}}, s1_num}) *
               $signed({{(XW-DW-1){1'b0}}, slot_q[i].den}) >
               $signed({{(XW-NW){slot_q[i].num[NW-1]}}, slot_q[i].num}) *
               $signed({{(XW-DW-1){1'b0}}, s1_den}));
      if (slot_q[i].vld && !gt[i]) pos = pos + RW'(1);
    end
  end

  assign ins = s1_vld & ~s1_drop;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ACCUM;
      rank     <= '0;
      s1_vld   <= 1'b0;
      s1_drop  <= 1'b0;
      s1_addr  <= '0;
      s1_set   <= '0;
      s1_num   <= '0;
      s1_den   <= '0;
      drop_cnt <= '0;
      for (int i = 0; i < K; i++) slot_q[i] <= '0;
    end else begin
      s1_vld <= accept;
      if (accept) begin
        s1_drop <= (d_in == '0);
        s1_addr <= addr_in;
        s1_set  <= set_in;
        s1_num  <= n_in;
        s1_den  <= d_in;
      end
      if (s1_vld && s1_drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;

      if (ins) begin
        for (int i = 1; i < K; i++)
          if (RW'(i) > pos) slot_q[i] <= slot_q[i-1];
        for (int i = 0; i < K; i++)
          if (RW'(i) == pos) slot_q[i] <= '{vld: 1'b1, addr: s1_addr, set: s1_set, num: s1_num, den: s1_den};
      end

      case (state)
        ACCUM: if (accept && last_in) state <= FLUSH;
        FLUSH: begin
          state <= DRAIN;
          rank  <= '0;
        end
        DRAIN: if (out_ready) begin
          if (rank == RW'(K-1)) begin
            state    <= ACCUM;
            rank     <= '0;
            drop_cnt <= '0;
            for (int i = 0; i < K; i++) slot_q[i] <= '0;
          end else begin
            rank <= rank + RW'(1);
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

  assign draining  = (state == DRAIN);
  assign cur       = slot_q[IW'(rank)];
  assign out_valid = draining;
  assign out_hit   = draining & cur.vld;
  assign out_rank  = draining ? rank : '0;
  assign out_addr  = draining ? cur.addr : '0;
  assign out_set   = draining ? cur.set : '0;
  assign out_num   = draining ? cur.num : '0;
  assign out_den   = draining ? cur.den : '0;
  assign out_last  = draining && (rank == RW'(K-1));

endmodule

// File: tb/tb_dprob_topk_select.sv
// Directed bench for dprob_topk_select: hand-computed ranking, sign select, ties, drops, backpressure and reset.
module tb_dprob_topk_select;

  logic               clk = 1'b0;
  logic               reset;
  logic               valid_in;
  logic               in_ready;
  logic               last_in;
  logic signed [15:0] prob_max_in;
  logic signed [15:0] prob_min_in;
  logic signed [15:0] prob_sum_in;
  logic [15:0]        scale_in;
  logic [7:0]         addr_in;
  logic [2:0]         set_in;
  logic               out_valid;
  logic               out_ready;
  logic               out_hit;
  logic [2:0]         out_rank;
  logic [7:0]         out_addr;
  logic [2:0]         out_set;
  logic signed [32:0] out_num;
  logic [16:0]        out_den;
  logic               out_last;
  logic [15:0]        drop_cnt;

  int n_cmp = 0;
  int n_err = 0;

  dprob_topk_select #(.DW(16), .AW(8), .SW(3), .K(4)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .in_ready(in_ready), .last_in(last_in),
    .prob_max_in(prob_max_in), .prob_min_in(prob_min_in), .prob_sum_in(prob_sum_in),
    .scale_in(scale_in), .addr_in(addr_in), .set_in(set_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_hit(out_hit), .out_rank(out_rank),
    .out_addr(out_addr), .out_set(out_set), .out_num(out_num), .out_den(out_den),
    .out_last(out_last), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no end of test, expected finish before timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Presents one sample for exactly one accepting edge (in_ready is high throughout ACCUM).
  task automatic send(input logic signed [15:0] mx, input logic signed [15:0] mn,
                      input logic signed [15:0] sm, input logic [15:0] sc,
                      input logic [7:0] ad, input logic [2:0] st, input logic lst);
    valid_in = 1'b1; prob_max_in = mx; prob_min_in = mn; prob_sum_in = sm;
    scale_in = sc; addr_in = ad; set_in = st; last_in = lst;
    @(posedge clk); #1;
    valid_in = 1'b0; last_in = 1'b0;
  endtask

  // Called right after the frame-last sample was accepted: FLUSH cycle, then DRAIN.
  task automatic after_last(input string tag);
    chk({tag, "_flush_in_ready"}, 64'(in_ready), 64'd0);
    chk({tag, "_flush_out_valid"}, 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    chk({tag, "_t2_out_valid"}, 64'(out_valid), 64'd1);
  endtask

  task automatic beat(input string tag, input logic hit, input int rank, input int ad, input int st,
                      input longint num, input int den, input logic lst);
    int c;
    c = 0;
    while (!out_valid && c < 20) begin
      @(posedge clk); #1;
      c++;
    end
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_hit"}, 64'(out_hit), 64'(hit));
    chk({tag, "_rank"}, 64'(out_rank), 64'(rank));
    chk({tag, "_last"}, 64'(out_last), 64'(lst));
    if (hit) begin
      chk({tag, "_addr"}, 64'(out_addr), 64'(ad));
      chk({tag, "_set"}, 64'(out_set), 64'(st));
      chk({tag, "_num"}, 64'(out_num), 64'(num));
      chk({tag, "_den"}, 64'(out_den), 64'(den));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    if (lst) chk({tag, "_in_ready_after"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    reset = 1'b1; valid_in = 1'b0; last_in = 1'b0; out_ready = 1'b0;
    prob_max_in = '0; prob_min_in = '0; prob_sum_in = '0; scale_in = '0; addr_in = '0; set_in = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_hit", 64'(out_hit), 64'd0);
    chk("rst_out_last", 64'(out_last), 64'd0);
    chk("rst_out_rank", 64'(out_rank), 64'd0);
    chk("rst_out_num", 64'(out_num), 64'd0);
    chk("rst_out_den", 64'(out_den), 64'd0);
    chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);

    // Basic ranking: scores 2, 5, 3.
    send(16'sd4, 16'sd0, 16'sd2, 16'd1, 8'd0, 3'd1, 1'b0);
    send(16'sd10, 16'sd0, 16'sd2, 16'd1, 8'd1, 3'd2, 1'b0);
    send(16'sd9, 16'sd0, 16'sd3, 16'd1, 8'd2, 3'd3, 1'b1);
    after_last("f1");
    beat("f1_r0", 1'b1, 0, 1, 2, 10, 2, 1'b0);
    beat("f1_r1", 1'b1, 1, 2, 3, 9, 3, 1'b0);
    beat("f1_r2", 1'b1, 2, 0, 1, 4, 2, 1'b0);
    beat("f1_r3", 1'b0, 3, 0, 0, 0, 0, 1'b1);

    // Negative sum selects min and flips signs: -6/-2 -> 6/2.
    send(16'sd100, -16'sd6, -16'sd2, 16'd1, 8'd5, 3'd5, 1'b0);
    send(16'sd4, 16'sd0, 16'sd2, 16'd1, 8'd6, 3'd6, 1'b1);
    after_last("f2");
    beat("f2_r0", 1'b1, 0, 5, 5, 6, 2, 1'b0);
    beat("f2_r1", 1'b1, 1, 6, 6, 4, 2, 1'b0);
    beat("f2_r2", 1'b0, 2, 0, 0, 0, 0, 1'b0);
    beat("f2_r3", 1'b0, 3, 0, 0, 0, 0, 1'b1);

    // Overflow and tie: scores 1,6,3(6/2),5,3(3/1),4; a4 ties a2 and falls off.
    send(16'sd1, 16'sd0, 16'sd1, 16'd1, 8'd0, 3'd0, 1'b0);
    send(16'sd6, 16'sd0, 16'sd1, 16'd1, 8'd1, 3'd0, 1'b0);
    send(16'sd6, 16'sd0, 16'sd2, 16'd1, 8'd2, 3'd0, 1'b0);
    send(16'sd5, 16'sd0, 16'sd1, 16'd1, 8'd3, 3'd0, 1'b0);
    send(16'sd3, 16'sd0, 16'sd1, 16'd1, 8'd4, 3'd0, 1'b0);
    send(16'sd4, 16'sd0, 16'sd1, 16'd1, 8'd5, 3'd0, 1'b1);
    after_last("f3");
    beat("f3_r0", 1'b1, 0, 1, 0, 6, 1, 1'b0);
    beat("f3_r1", 1'b1, 1, 3, 0, 5, 1, 1'b0);
    beat("f3_r2", 1'b1, 2, 5, 0, 4, 1, 1'b0);
    beat("f3_r3", 1'b1, 3, 2, 0, 6, 2, 1'b1);

    // Zero-sum samples are dropped and counted.
    send(16'sd50, 16'sd0, 16'sd0, 16'd1, 8'd0, 3'd0, 1'b0);
    send(16'sd60, 16'sd0, 16'sd0, 16'd1, 8'd1, 3'd0, 1'b0);
    send(16'sd7, 16'sd0, 16'sd1, 16'd1, 8'd2, 3'd4, 1'b1);
    after_last("f4");
    chk("f4_drop_cnt", 64'(drop_cnt), 64'd2);
    beat("f4_r0", 1'b1, 0, 2, 4, 7, 1, 1'b0);
    beat("f4_r1", 1'b0, 1, 0, 0, 0, 0, 1'b0);
    beat("f4_r2", 1'b0, 2, 0, 0, 0, 0, 1'b0);
    beat("f4_r3", 1'b0, 3, 0, 0, 0, 0, 1'b1);
    chk("f4_drop_cnt_cleared", 64'(drop_cnt), 64'd0);

    // Backpressure at rank1 with a stray valid_in pulse during DRAIN.
    send(16'sd5, 16'sd0, 16'sd1, 16'd3, 8'd7, 3'd1, 1'b0);
    send(16'sd2, 16'sd0, 16'sd1, 16'd3, 8'd8, 3'd2, 1'b1);
    after_last("f5");
    beat("f5_r0", 1'b1, 0, 7, 1, 15, 1, 1'b0);
    valid_in = 1'b1; prob_max_in = 16'sd1000; prob_sum_in = 16'sd1; scale_in = 16'd1;
    addr_in = 8'd77; last_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("f5_hold_valid", 64'(out_valid), 64'd1);
      chk("f5_hold_rank", 64'(out_rank), 64'd1);
      chk("f5_hold_addr", 64'(out_addr), 64'd8);
      chk("f5_hold_num", 64'(out_num), 64'd6);
      chk("f5_hold_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
    end
    valid_in = 1'b0; last_in = 1'b0;
    beat("f5_r1", 1'b1, 1, 8, 2, 6, 1, 1'b0);
    beat("f5_r2", 1'b0, 2, 0, 0, 0, 0, 1'b0);
    beat("f5_r3", 1'b0, 3, 0, 0, 0, 0, 1'b1);
    send(16'sd3, 16'sd0, 16'sd1, 16'd1, 8'd9, 3'd7, 1'b1);
    after_last("f6");
    beat("f6_r0", 1'b1, 0, 9, 7, 3, 1, 1'b0);
    beat("f6_r1", 1'b0, 1, 0, 0, 0, 0, 1'b0);
    beat("f6_r2", 1'b0, 2, 0, 0, 0, 0, 1'b0);
    beat("f6_r3", 1'b0, 3, 0, 0, 0, 0, 1'b1);

    // Reset mid-drain discards the list.
    send(16'sd2, 16'sd0, 16'sd1, 16'd1, 8'd10, 3'd0, 1'b0);
    send(16'sd3, 16'sd0, 16'sd1, 16'd1, 8'd11, 3'd0, 1'b0);
    send(16'sd1, 16'sd0, 16'sd1, 16'd1, 8'd12, 3'd0, 1'b1);
    after_last("f7");
    beat("f7_r0", 1'b1, 0, 11, 0, 3, 1, 1'b0);
    beat("f7_r1", 1'b1, 1, 10, 0, 2, 1, 1'b0);
    chk("f7_at_rank2", 64'(out_rank), 64'd2);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("f7_rst_out_valid", 64'(out_valid), 64'd0);
    chk("f7_rst_in_ready", 64'(in_ready), 64'd1);
    send(16'sd8, 16'sd0, 16'sd4, 16'd1, 8'd13, 3'd3, 1'b1);
    after_last("f8");
    beat("f8_r0", 1'b1, 0, 13, 3, 8, 4, 1'b0);
    beat("f8_r1", 1'b0, 1, 0, 0, 0, 0, 1'b0);
    beat("f8_r2", 1'b0, 2, 0, 0, 0, 0, 1'b0);
    beat("f8_r3", 1'b0, 3, 0, 0, 0, 0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
